// File: rtl/core_scheduler.sv
// Per-core instruction scheduler: walks each instruction through fetch, decode,
// memory request/wait, execute and update, and tracks pc and retired count.
module core_scheduler #(
    parameter int THREADS = 4,
    parameter int PC_BITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               instr_req,
    output logic [PC_BITS-1:0] instr_addr,
    input  logic               instr_valid,
    output logic               decode_en,
    input  logic               is_ldr,
    input  logic               is_str,
    input  logic               is_branch,
    input  logic               is_halt,
    input  logic               wb_en_class,
    input  logic               branch_taken,
    input  logic [PC_BITS-1:0] IMM8,
    output logic               lsu_start,
    input  logic [THREADS-1:0] lsu_busy,
    output logic               reg_we,
    output logic [PC_BITS-1:0] pc,
    output logic [2:0]         core_state,
    output logic [15:0]        retired,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_REQUEST = 3'd3,
        ST_WAIT    = 3'd4,
        ST_EXECUTE = 3'd5,
        ST_UPDATE  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    state_t             state_reg, state_next;
    logic [PC_BITS-1:0] pc_reg, pc_next;
    logic [15:0]        retired_reg, retired_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        retired_next = retired_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_FETCH;
                    pc_next      = '0;
                    retired_next = '0;
                end
            end
            ST_FETCH:   if (instr_valid) state_next = ST_DECODE;
            ST_DECODE:  state_next = ST_REQUEST;
            ST_REQUEST: state_next = ST_WAIT;
            // The LSU raises busy one cycle after lsu_start, so the first WAIT
            // cycle already sees the outstanding bits.
            ST_WAIT:    if (lsu_busy == '0) state_next = ST_EXECUTE;
            ST_EXECUTE: state_next = ST_UPDATE;
            ST_UPDATE: begin
                if (retired_reg != 16'hFFFF) retired_next = retired_reg + 16'd1;
                if (is_halt) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FETCH;
                    pc_next    = (is_branch && branch_taken) ? IMM8 : pc_reg + PC_BITS'(1);
                end
            end
            ST_DONE:    state_next = ST_DONE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset clears them at once.
    assign instr_req  = (state_reg == ST_FETCH);
    assign decode_en  = (state_reg == ST_DECODE);
    assign lsu_start  = (state_reg == ST_REQUEST) && (is_ldr || is_str);
    assign reg_we     = (state_reg == ST_UPDATE) && wb_en_class && !is_halt;
    assign done       = (state_reg == ST_DONE);
    assign instr_addr = pc_reg;
    assign pc         = pc_reg;
    assign core_state = state_reg;
    assign retired    = retired_reg;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: walks short programs through the FSM and
// checks state, strobes, pc and retired count against hand-computed values.
module tb_core_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic        decode_en;
    logic        is_ldr, is_str, is_branch, is_halt;
    logic        wb_en_class;
    logic        branch_taken;
    logic [7:0]  IMM8;
    logic        lsu_start;
    logic [3:0]  lsu_busy;
    logic        reg_we;
    logic [7:0]  pc;
    logic [2:0]  core_state;
    logic [15:0] retired;
    logic        done;

    int total = 0;
    int bad   = 0;

    core_scheduler #(.THREADS(4), .PC_BITS(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_valid  (instr_valid),
        .decode_en    (decode_en),
        .is_ldr       (is_ldr),
        .is_str       (is_str),
        .is_branch    (is_branch),
        .is_halt      (is_halt),
        .wb_en_class  (wb_en_class),
        .branch_taken (branch_taken),
        .IMM8         (IMM8),
        .lsu_start    (lsu_start),
        .lsu_busy     (lsu_busy),
        .reg_we       (reg_we),
        .pc           (pc),
        .core_state   (core_state),
        .retired      (retired),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        is_ldr = 0; is_str = 0; is_branch = 0; is_halt = 0;
        wb_en_class = 0; branch_taken = 0; IMM8 = 8'h00;
        instr_valid = 0; lsu_busy = 4'h0; start = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_flags();
        tick();
        reset = 1'b0;
        #1;
        check_val("rst_state", 32'(core_state), 32'd0);
        check_val("rst_pc", 32'(pc), 32'd0);
    endtask

    task automatic start_kernel();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_state", 32'(core_state), 32'd1);
        check_val("start_pc", 32'(pc), 32'd0);
        check_val("start_ret", 32'(retired), 32'd0);
    endtask

    // Runs one instruction starting in FETCH and ending after UPDATE.
    task automatic do_instr(input logic ld, input logic st, input logic br, input logic hl,
                            input logic wb, input logic tk, input logic [7:0] imm,
                            input int vdelay, input int busy_n,
                            input logic [7:0] exp_pc, input logic [15:0] exp_ret);
        int req_cnt = 0;
        int dec_cnt = 0;
        logic [7:0] pc_before = pc;
        is_ldr = ld; is_str = st; is_branch = br; is_halt = hl;
        wb_en_class = wb; branch_taken = tk; IMM8 = imm;
        for (int i = 0; i < vdelay; i++) begin
            instr_valid = 1'b0;
            #1;
            req_cnt += int'(instr_req);
            dec_cnt += int'(decode_en);
            check_val("fetch_hold", 32'(core_state), 32'd1);
            tick();
        end
        instr_valid = 1'b1;
        #1;
        req_cnt += int'(instr_req);
        dec_cnt += int'(decode_en);
        tick();
        instr_valid = 1'b0;
        #1;
        req_cnt += int'(instr_req);
        dec_cnt += int'(decode_en);
        check_val("decode_state", 32'(core_state), 32'd2);
        tick();
        dec_cnt += int'(decode_en);
        check_val("request_state", 32'(core_state), 32'd3);
        check_val("lsu_start", 32'(lsu_start), 32'(ld | st));
        check_val("instr_req_cycles", 32'(req_cnt), 32'(vdelay + 1));
        check_val("decode_pulses", 32'(dec_cnt), 32'd1);
        tick();
        check_val("wait_state", 32'(core_state), 32'd4);
        check_val("wait_lsu_start", 32'(lsu_start), 32'd0);
        for (int i = 0; i < busy_n; i++) begin
            lsu_busy = 4'b0101;
            #1;
            check_val("wait_busy", 32'(core_state), 32'd4);
            tick();
        end
        lsu_busy = 4'h0;
        tick();
        check_val("execute_state", 32'(core_state), 32'd5);
        tick();
        check_val("update_state", 32'(core_state), 32'd6);
        check_val("update_reg_we", 32'(reg_we), 32'(wb & ~hl));
        tick();
        check_val("retired", 32'(retired), 32'(exp_ret));
        check_val("reg_we_off", 32'(reg_we), 32'd0);
        if (hl) begin
            check_val("halt_state", 32'(core_state), 32'd7);
            check_val("halt_done", 32'(done), 32'd1);
            check_val("halt_pc", 32'(pc), 32'(pc_before));
        end else begin
            check_val("next_state", 32'(core_state), 32'd1);
            check_val("next_addr", 32'(instr_addr), 32'(exp_pc));
        end
        $display("instr pc=%0d -> addr=%0d retired=%0d state=%0d", pc_before, instr_addr, retired, core_state);
        clear_flags();
    endtask

    initial begin
        reset = 1'b1;
        clear_flags();
        #12;
        check_val("init_state", 32'(core_state), 32'd0);
        check_val("init_pc", 32'(pc), 32'd0);
        check_val("init_ret", 32'(retired), 32'd0);
        check_val("init_strobes", 32'({instr_req, decode_en, lsu_start, reg_we, done}), 32'd0);
        reset = 1'b0;
        instr_valid = 1'b1;
        lsu_busy    = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("idle_no_start", 32'(core_state), 32'd0);
        end
        clear_flags();

        // CONST, ADD, HALT
        start_kernel();
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'd1, 16'd1);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'd2, 16'd2);
        do_instr(0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 8'd2, 16'd3);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("done_hold", 32'({done, core_state}), 32'hF);
        end
        check_val("done_pc", 32'(pc), 32'd2);
        check_val("done_ret", 32'(retired), 32'd3);
        start = 1'b0;

        // LDR with long busy, delayed fetch, branch not taken at pc=3
        do_reset();
        start_kernel();
        do_instr(1, 0, 0, 0, 1, 0, 8'h00, 0, 5, 8'd1, 16'd1);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 3, 0, 8'd2, 16'd2);
        do_instr(0, 1, 0, 0, 0, 0, 8'h00, 0, 2, 8'd3, 16'd3);
        do_instr(0, 0, 1, 0, 0, 0, 8'h10, 0, 0, 8'd4, 16'd4);

        // Branch taken at pc=3, then jump to 255 and wrap
        do_reset();
        start_kernel();
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'd1, 16'd1);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 1, 0, 8'd2, 16'd2);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'd3, 16'd3);
        do_instr(0, 0, 1, 0, 0, 1, 8'h10, 0, 0, 8'd16, 16'd4);
        do_instr(0, 0, 1, 0, 0, 1, 8'hFF, 0, 0, 8'd255, 16'd5);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'd0, 16'd6);
        do_instr(0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'd1, 16'd7);

        // Reset asserted mid-WAIT of an LDR
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        is_ldr = 1'b1;
        tick();
        check_val("mid_request_lsu_start", 32'(lsu_start), 32'd1);
        tick();
        lsu_busy = 4'b0101;
        tick();
        check_val("mid_wait_state", 32'(core_state), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_state", 32'(core_state), 32'd0);
        check_val("async_rst_pc", 32'(pc), 32'd0);
        check_val("async_rst_lsu_start", 32'(lsu_start), 32'd0);
        check_val("async_rst_ret", 32'(retired), 32'd0);
        tick();
        reset = 1'b0;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("post_rst_idle", 32'({instr_req, core_state}), 32'd0);
        end
        clear_flags();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
